// File: rtl/conv_8b_to_32b.sv
// -----------------------------------------------------------------------------
// conv_8b_to_32b
// Reassembles a contiguous byte stream, as produced by the 32b->8b serialiser,
// into 32-bit words. Runs entirely in the clk_4f domain. Each group of four
// bytes accepted on consecutive edges yields one word with a single-cycle
// valid_out strobe. A gap in the middle of a word throws away the bytes held
// so far and raises frag_err for one cycle.
//
// Parameters
//   MSB_FIRST : 1 = byte 0 of a word lands in data_out[31:24]
//               0 = byte 0 of a word lands in data_out[7:0]
//   HOLD_LAST : 1 = data_out keeps the last complete word between strobes
//               0 = data_out reads 0 whenever valid_out is low
//
// Ports
//   clk_4f    in   1   byte-rate clock, rising edge
//   reset_L   in   1   asynchronous active-low reset
//   data_in   in   8   byte from the serialiser
//   valid_in  in   1   data_in is valid this cycle
//   data_out  out  32  reassembled word (registered)
//   valid_out out  1   one-cycle strobe, data_out holds a new word
//   frag_err  out  1   one-cycle strobe, a partial word was discarded
//   byte_idx  out  2   lane counter (number of bytes held)
//
// States
//   ST_IDLE    | no bytes held, byte_idx = 0
//   ST_COLLECT | 1 to 3 bytes held
// -----------------------------------------------------------------------------
module conv_8b_to_32b #(
    parameter bit MSB_FIRST = 1'b1,
    parameter bit HOLD_LAST = 1'b1
) (
    input  logic        clk_4f,
    input  logic        reset_L,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        frag_err,
    output logic [1:0]  byte_idx
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [31:0] asm_q;
    logic [31:0] data_q;
    logic        valid_q;
    logic        frag_q;

    logic [1:0]  lane_sel;
    logic [31:0] asm_d;

    // Lane k sits at bit offset 8k (LSB first) or 8(3-k) (MSB first);
    // ~k equals 3-k on a 2-bit counter.
    always_comb begin
        lane_sel = MSB_FIRST ? ~idx_q : idx_q;
        asm_d    = asm_q;
        asm_d[{lane_sel, 3'b000} +: 8] = data_in;
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            asm_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            frag_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            frag_q  <= 1'b0;
            if (!HOLD_LAST) begin
                data_q <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    // data_in is never looked at unless valid_in is set, so
                    // X on an idle bus cannot reach the assembly register.
                    if (valid_in) begin
                        asm_q   <= asm_d;
                        idx_q   <= 2'd1;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (valid_in) begin
                        if (idx_q == 2'd3) begin
                            data_q  <= asm_d;
                            valid_q <= 1'b1;
                            asm_q   <= '0;
                            idx_q   <= 2'd0;
                            state_q <= ST_IDLE;
                        end else begin
                            asm_q <= asm_d;
                            idx_q <= idx_q + 2'd1;
                        end
                    end else begin
                        // Gap inside a word: drop held bytes, data_out untouched.
                        frag_q  <= 1'b1;
                        asm_q   <= '0;
                        idx_q   <= 2'd0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    asm_q   <= '0;
                    idx_q   <= 2'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign frag_err  = frag_q;
    assign byte_idx  = idx_q;

endmodule

// File: tb/tb_conv_8b_to_32b.sv
module tb_conv_8b_to_32b;

    logic        clk_4f;
    logic        reset_L;
    logic [7:0]  data_in;
    logic        valid_in;

    // MSB_FIRST=1, HOLD_LAST=1
    logic [31:0] data_out;
    logic        valid_out;
    logic        frag_err;
    logic [1:0]  byte_idx;
    // MSB_FIRST=0, HOLD_LAST=1
    logic [31:0] data_out_l;
    logic        valid_out_l;
    logic        frag_err_l;
    logic [1:0]  byte_idx_l;
    // MSB_FIRST=1, HOLD_LAST=0
    logic [31:0] data_out_n;
    logic        valid_out_n;
    logic        frag_err_n;
    logic [1:0]  byte_idx_n;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0]  mq[$];
    logic [31:0] sb[$];
    logic        exp_valid = 1'b0;
    logic        exp_frag  = 1'b0;
    logic [1:0]  exp_idx   = 2'd0;
    logic [31:0] last_msb  = '0;
    logic [31:0] last_lsb  = '0;

    conv_8b_to_32b #(.MSB_FIRST(1'b1), .HOLD_LAST(1'b1)) dut (
        .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out), .frag_err(frag_err), .byte_idx(byte_idx)
    );

    conv_8b_to_32b #(.MSB_FIRST(1'b0), .HOLD_LAST(1'b1)) dut_lsb (
        .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out_l), .valid_out(valid_out_l), .frag_err(frag_err_l), .byte_idx(byte_idx_l)
    );

    conv_8b_to_32b #(.MSB_FIRST(1'b1), .HOLD_LAST(1'b0)) dut_nh (
        .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out_n), .valid_out(valid_out_n), .frag_err(frag_err_n), .byte_idx(byte_idx_n)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: collect bytes in a queue; four in a row make a word,
    // a gap with bytes pending is a fragment.
    task automatic model_edge(input logic v, input logic [7:0] d);
        exp_valid = 1'b0;
        exp_frag  = 1'b0;
        if (v) begin
            mq.push_back(d);
            if (mq.size() == 4) begin
                last_msb  = {mq[0], mq[1], mq[2], mq[3]};
                last_lsb  = {mq[3], mq[2], mq[1], mq[0]};
                exp_valid = 1'b1;
                mq.delete();
            end
        end else if (mq.size() != 0) begin
            exp_frag = 1'b1;
            mq.delete();
        end
        exp_idx = 2'(mq.size());
    endtask

    task automatic check_all();
        check_val("valid_out",       {31'd0, valid_out},   {31'd0, exp_valid});
        check_val("frag_err",        {31'd0, frag_err},    {31'd0, exp_frag});
        check_val("byte_idx",        {30'd0, byte_idx},    {30'd0, exp_idx});
        check_val("data_out",        data_out,             last_msb);
        check_val("data_out_lsb",    data_out_l,           last_lsb);
        check_val("valid_out_lsb",   {31'd0, valid_out_l}, {31'd0, exp_valid});
        check_val("frag_err_lsb",    {31'd0, frag_err_l},  {31'd0, exp_frag});
        check_val("data_out_nohold", data_out_n,           exp_valid ? last_msb : 32'd0);
        check_val("valid_out_nohold",{31'd0, valid_out_n}, {31'd0, exp_valid});
        check_val("byte_idx_nohold", {30'd0, byte_idx_n},  {30'd0, exp_idx});
        check_val("valid_and_frag",  {31'd0, valid_out & frag_err}, 32'd0);
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, check at
    // the following falling edge.
    task automatic step(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = v ? d : 8'hxx;
        @(posedge clk_4f);
        model_edge(v, d);
        @(negedge clk_4f);
        check_all();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, w[8*i +: 8]);
        end
    endtask

    initial begin
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (2) @(negedge clk_4f);
        check_all();
        reset_L = 1'b1;

        // Single word, then idle gap (no error expected after a complete word)
        send_word(32'hDEADBEEF);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        // Three back-to-back words
        send_word(32'h01020304);
        send_word(32'hA5A5A5A5);
        send_word(32'hFFFFFFFF);
        step(1'b0, 8'h00);

        // Fragment, then a full word
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b0, 8'h00);
        send_word(32'h33445566);
        step(1'b0, 8'h00);

        // Asynchronous reset mid-word
        step(1'b1, 8'h77);
        step(1'b1, 8'h88);
        #2;
        valid_in = 1'b0;
        reset_L  = 1'b0;
        #1;
        mq.delete();
        last_msb  = '0;
        last_lsb  = '0;
        exp_valid = 1'b0;
        exp_frag  = 1'b0;
        exp_idx   = 2'd0;
        check_val("rst_data_out", data_out, 32'd0);
        check_val("rst_byte_idx", {30'd0, byte_idx}, 32'd0);
        check_val("rst_valid_out", {31'd0, valid_out}, 32'd0);
        #1;
        reset_L = 1'b1;
        step(1'b0, 8'h00);
        send_word(32'hCAFEF00D);
        step(1'b0, 8'h00);

        // Random traffic with occasional gaps
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) < 8, 8'($urandom));
        end
        step(1'b0, 8'h00);

        // End-to-end: random words serialised MSB-first, contiguous
        for (int i = 0; i < 40; i++) begin
            logic [31:0] w;
            w = $urandom;
            sb.push_back(w);
            for (int b = 3; b >= 0; b--) begin
                step(1'b1, w[8*b +: 8]);
                if (valid_out) begin
                    if (sb.size() == 0) begin
                        check_val("e2e_extra_word", data_out, 32'd0);
                    end else begin
                        check_val("e2e_word", data_out, sb.pop_front());
                    end
                end
            end
        end
        step(1'b0, 8'h00);
        check_val("e2e_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_8b_to_32b.md
Name: conv_8b_to_32b

Overview:
- Receive-side counterpart of the 32b→8b converter: reassembles a contiguous byte stream into 32-bit words.
- Sits after the serialising path. Consumes data_in/valid_in as produced by the 32b→8b converter's data_out/valid_out.
- Runs entirely in the clk_4f domain. Emits one 32-bit word, with a single-cycle valid strobe, per four accepted bytes.
- Flags and discards fragmented words.

Parameters:
- MSB_FIRST, 1: 1 = first byte of a word lands in data_out[31:24]; 0 = first byte lands in data_out[7:0].
- HOLD_LAST, 1: 1 = data_out holds the last complete word between strobes; 0 = data_out forced to 0 whenever valid_out=0.

Ports:
- clk_4f, input, 1: byte-rate clock, rising edge.
- reset_L, input, 1: asynchronous active-low reset.
- data_in, input, 8: byte from serialiser.
- valid_in, input, 1: data_in valid this cycle.
- data_out, output, 32: reassembled word (registered).
- valid_out, output, 1: one-cycle strobe, data_out is a new complete word.
- frag_err, output, 1: one-cycle strobe, a partial word was discarded.
- byte_idx, output, 2: current lane counter, for debug/verification.

Behaviour:
- Reset (reset_L=0, async, no clock needed): data_out=0, valid_out=0, frag_err=0, byte_idx=0, shift/assembly register=0, state=IDLE.
- Release is synchronous in effect: the first sampling edge is the first clk_4f rise with reset_L=1.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states:
  - IDLE: byte_idx=0, no bytes held.
  - COLLECT: 1–3 bytes held.
- Accepted byte = valid_in=1 at a clk_4f rising edge.
- Lane placement:
  - MSB_FIRST=1: byte k (k=0..3) goes to bits [31-8k -: 8].
  - MSB_FIRST=0: byte k goes to bits [8k +: 8].
- Transitions:
  - IDLE + accepted byte → COLLECT, byte_idx=1.
  - COLLECT + accepted byte with byte_idx<3 → byte_idx+1.
  - COLLECT + accepted byte with byte_idx=3 → word complete. At this edge, data_out ← assembled word including the current byte, valid_out ← 1, byte_idx ← 0, state ← IDLE.
  - COLLECT + valid_in=0 → fragment. Held bytes are discarded, frag_err ← 1 for one cycle, byte_idx ← 0, state ← IDLE. valid_out stays 0 and data_out is unchanged.
  - IDLE + valid_in=0 → stay. No error.
- Latency: valid_out and data_out become visible on the same edge that samples the 4th byte. They are observable during the cycle after the 4th byte is presented.
- valid_out is high for exactly 1 clk_4f cycle per word.
- Back-to-back words with no gap: strobes occur every 4 cycles. Byte 0 of the next word is accepted on the cycle immediately after byte 3, with no bubble required.
- data_out when valid_out=0:
  - HOLD_LAST=1: holds the previous word.
  - HOLD_LAST=0: 0.
- data_in is ignored when valid_in=0, including X values. Nothing X may propagate to outputs.
- Simultaneous events:
  - valid_out and frag_err are never both 1 in the same cycle.
  - A gap that directly follows a completed word is not an error.
- Reset mid-word: partial bytes are lost, no frag_err is issued, and the next accepted byte is lane 0.
- There is no backpressure. The block always accepts.

Test Plan:
- Reset, then bytes 0xDE,0xAD,0xBE,0xEF on 4 consecutive cycles (MSB_FIRST=1) → data_out=0xDEADBEEF with valid_out=1 for exactly 1 cycle, one cycle after 0xEF; byte_idx returns to 0.
- Same stream with MSB_FIRST=0 → data_out=0xEFBEADDE.
- Three words back-to-back (0x01020304, 0xA5A5A5A5, 0xFFFFFFFF serialised MSB-first, 12 contiguous valid cycles) → three strobes at 4-cycle spacing with the correct words; frag_err stays 0.
- Bytes 0x11,0x22, then valid_in=0 for 1 cycle, then 0x33,0x44,0x55,0x66 → frag_err pulses once; valid_out=0 during the fragment; next strobe gives 0x33445566.
- reset_L driven low asynchronously between clock edges after 2 bytes → outputs 0 immediately; after release, 4 bytes 0xCAFEF00D-serialised → 0xCAFEF00D, no frag_err.
- End-to-end: 32b→8b converter output (clk/clk_4f domain) drives this block; random words with valid_in=1 → every reconstructed word matches its source in order; HOLD_LAST=0 run shows data_out=0 between strobes.
